// File: rtl/dac_play_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : dac_play_ctrl
// Brief   : I2S lock qualification, soft-ramped gain and PCM/DSD switch sequencing
// Rev     : 1.0
// ============================================================================
module dac_play_ctrl #(
    parameter int                GAIN_W        = 16,
    parameter logic [GAIN_W-1:0] RAMP_STEP     = 'h0800,
    parameter int                LOCK_FRAMES   = 16,
    parameter int                LOSS_TIMEOUT  = 4096,
    parameter int                SWITCH_CYCLES = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              data_l_stb_i,
    input  logic              data_r_stb_i,
    input  logic              dsd_oe_i,
    input  logic              mute_req_i,
    input  logic              ramp_stb_i,
    output logic [GAIN_W-1:0] gain_o,
    output logic              dsd_sel_o,
    output logic              dsm_rst_o,
    output logic              locked_o,
    output logic [2:0]        state_o
);
    localparam int FC_W = $clog2(LOCK_FRAMES + 1);
    localparam int WD_W = $clog2(LOSS_TIMEOUT + 1);
    localparam int SW_W = $clog2(SWITCH_CYCLES + 1);
    localparam logic [FC_W-1:0]   C_LOCK_FRAMES = FC_W'(LOCK_FRAMES);
    localparam logic [WD_W-1:0]   C_WD_LAST     = WD_W'(LOSS_TIMEOUT - 1);
    localparam logic [SW_W-1:0]   C_SW_LAST     = SW_W'(SWITCH_CYCLES - 1);
    localparam logic [GAIN_W:0]   C_UNITY_W     = (GAIN_W+1)'(1) << (GAIN_W - 1);
    localparam logic [GAIN_W-1:0] C_UNITY       = C_UNITY_W[GAIN_W-1:0];

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RAMP_UP   = 3'd1,
        S_RUN       = 3'd2,
        S_RAMP_DOWN = 3'd3,
        S_SWITCH    = 3'd4
    } state_t;

    state_t            r_state;
    logic [1:0]        r_sync;
    logic [GAIN_W-1:0] r_gain;
    logic              r_dsd_sel;
    logic              r_dsm_rst;
    logic              r_locked;
    logic [FC_W-1:0]   r_frame_cnt;
    logic              r_l_pend;
    logic [WD_W-1:0]   r_wd_cnt;
    logic [SW_W-1:0]   r_sw_cnt;

    state_t            w_state_nxt;
    logic              w_mode_req;
    logic              w_mismatch;
    logic [GAIN_W-1:0] w_gain_nxt;
    logic              w_dsd_sel_nxt;
    logic              w_dsm_rst_nxt;
    logic [SW_W-1:0]   w_sw_cnt_nxt;
    logic              w_enter_sw;
    logic [GAIN_W:0]   w_gain_up;
    logic [GAIN_W:0]   w_gain_dn;
    logic [GAIN_W-1:0] w_up_sat;
    logic [GAIN_W-1:0] w_dn_sat;
    logic [FC_W-1:0]   w_frame_nxt;
    logic              w_l_pend_nxt;
    logic [WD_W-1:0]   w_wd_nxt;
    logic              w_timeout;
    logic              w_locked_nxt;

    assign w_mode_req = r_sync[1];
    assign w_mismatch = w_mode_req != r_dsd_sel;

    // One bit of headroom so the clamp sees overflow/underflow instead of a wrap
    assign w_gain_up = {1'b0, r_gain} + {1'b0, RAMP_STEP};
    assign w_gain_dn = {1'b0, r_gain} - {1'b0, RAMP_STEP};
    assign w_up_sat  = (w_gain_up >= C_UNITY_W) ? C_UNITY : w_gain_up[GAIN_W-1:0];
    assign w_dn_sat  = w_gain_dn[GAIN_W] ? '0 : w_gain_dn[GAIN_W-1:0];

    always_comb begin
        w_state_nxt   = r_state;
        w_gain_nxt    = r_gain;
        w_dsm_rst_nxt = 1'b0;
        w_sw_cnt_nxt  = '0;
        case (r_state)
            S_IDLE: begin
                w_gain_nxt = '0;
                if (w_mismatch)                     w_state_nxt = S_SWITCH;
                else if (r_locked && !mute_req_i)   w_state_nxt = S_RAMP_UP;
            end
            S_RAMP_UP: begin
                if (!r_locked) begin
                    w_state_nxt = S_IDLE;
                    w_gain_nxt  = '0;
                end else if (mute_req_i || w_mismatch) begin
                    w_state_nxt = S_RAMP_DOWN;
                end else if (ramp_stb_i) begin
                    w_gain_nxt = w_up_sat;
                    if (w_up_sat == C_UNITY) w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_gain_nxt = C_UNITY;
                if (!r_locked) begin
                    w_state_nxt = S_IDLE;
                    w_gain_nxt  = '0;
                end else if (mute_req_i || w_mismatch) begin
                    w_state_nxt = S_RAMP_DOWN;
                end
            end
            S_RAMP_DOWN: begin
                if (!r_locked) begin
                    w_state_nxt = S_IDLE;
                    w_gain_nxt  = '0;
                end else if (ramp_stb_i) begin
                    w_gain_nxt = w_dn_sat;
                    if (w_dn_sat == '0) w_state_nxt = w_mismatch ? S_SWITCH : S_IDLE;
                end else if (!mute_req_i && !w_mismatch) begin
                    w_state_nxt = S_RAMP_UP;
                end
            end
            S_SWITCH: begin
                w_gain_nxt = '0;
                if (r_sw_cnt == C_SW_LAST) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_dsm_rst_nxt = 1'b1;
                    w_sw_cnt_nxt  = r_sw_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gain_nxt  = '0;
            end
        endcase
        if (w_state_nxt == S_SWITCH) w_dsm_rst_nxt = 1'b1;
    end

    assign w_enter_sw    = (w_state_nxt == S_SWITCH) && (r_state != S_SWITCH);
    assign w_dsd_sel_nxt = w_enter_sw ? w_mode_req : r_dsd_sel;

    // A right strobe closes the pending left before a coincident left re-arms it
    always_comb begin
        w_frame_nxt  = r_frame_cnt;
        w_l_pend_nxt = r_l_pend;
        w_timeout    = 1'b0;
        w_wd_nxt     = r_wd_cnt + 1'b1;
        if (data_l_stb_i || data_r_stb_i) begin
            w_wd_nxt = '0;
        end else if (r_wd_cnt == C_WD_LAST) begin
            w_timeout = 1'b1;
            w_wd_nxt  = '0;
        end
        if (data_r_stb_i) begin
            if (!r_l_pend)                          w_frame_nxt = '0;
            else if (r_frame_cnt != C_LOCK_FRAMES)  w_frame_nxt = r_frame_cnt + 1'b1;
            w_l_pend_nxt = 1'b0;
        end
        if (data_l_stb_i) w_l_pend_nxt = 1'b1;
        if (w_timeout || w_enter_sw || w_dsd_sel_nxt) begin
            w_frame_nxt  = '0;
            w_l_pend_nxt = 1'b0;
            w_wd_nxt     = '0;
        end
        w_locked_nxt = w_dsd_sel_nxt || (w_frame_nxt == C_LOCK_FRAMES);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_sync      <= '0;
            r_gain      <= '0;
            r_dsd_sel   <= 1'b0;
            r_dsm_rst   <= 1'b1;
            r_locked    <= 1'b0;
            r_frame_cnt <= '0;
            r_l_pend    <= 1'b0;
            r_wd_cnt    <= '0;
            r_sw_cnt    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sync      <= {r_sync[0], dsd_oe_i};
            r_gain      <= w_gain_nxt;
            r_dsd_sel   <= w_dsd_sel_nxt;
            r_dsm_rst   <= w_dsm_rst_nxt;
            r_locked    <= w_locked_nxt;
            r_frame_cnt <= w_frame_nxt;
            r_l_pend    <= w_l_pend_nxt;
            r_wd_cnt    <= w_wd_nxt;
            r_sw_cnt    <= w_sw_cnt_nxt;
        end
    end

    assign gain_o    = r_gain;
    assign dsd_sel_o = r_dsd_sel;
    assign dsm_rst_o = r_dsm_rst;
    assign locked_o  = r_locked;
    assign state_o   = r_state;

endmodule
`default_nettype wire
